// File: rtl/glip_uart_pkg.sv
// glip_uart_pkg
//   Shared constants and state types for the host-side GLIP UART peer.
//   ESC starts every escape sequence on the line. CMD_LOGIC_RST follows ESC
//   to request a logic reset. CREDIT_HI_TAG marks the first payload byte of
//   a credit message.
package glip_uart_pkg;

  localparam logic [7:0] ESC           = 8'hFE;
  localparam logic [7:0] CMD_LOGIC_RST = 8'h01;
  localparam logic [1:0] CREDIT_HI_TAG = 2'b10;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_ESC,
    DEC_CRED_LO
  } dec_state_t;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_BYTE0,
    ENC_BYTE1,
    ENC_BYTE2
  } enc_state_t;

  // Which message the encoder is currently sending.
  typedef enum logic [1:0] {
    MSG_RST,
    MSG_CREDIT,
    MSG_DATA
  } msg_kind_t;

endpackage

// File: rtl/glip_uart_sync_fifo.sv
// glip_uart_sync_fifo
//   Single-clock first-word-fall-through FIFO with an occupancy output.
//   The head entry is presented on o_data whenever o_empty is low.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   i_push, i_data  write strobe and data (ignored while full)
//   i_pop           consume head entry (ignored while empty)
//   o_data          head entry
//   o_empty/o_full  status flags
//   o_count         number of stored entries
module glip_uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Read is combinational so the head byte is visible the cycle after it
  // was written, which the fall-through behaviour depends on.
  assign o_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/glip_uart_peer.sv
// glip_uart_peer
//   Host-side endpoint of the GLIP UART credit/escape protocol.
//   Egress: user bytes are escaped (FE -> FE FE) and spend one credit each;
//   credit messages and logic-reset commands are inserted between messages.
//   Ingress: the line is decoded into data bytes (buffered in an rx FIFO)
//   and credit messages (added to tx_credit); free rx space is granted back.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   tx_data/valid/ready      user egress byte stream
//   rx_data/valid/ready      user ingress byte stream
//   line_out_data/enable     byte to UART transmitter, enable held until done
//   line_out_done            transmitter finished current byte
//   line_in_data/enable      byte strobe from UART receiver
//   logic_rst_req            request a logic-reset command
//   tx_credit                current egress credit
//   error                    sticky protocol/overflow error
module glip_uart_peer
  import glip_uart_pkg::*;
#(
  parameter int CREDIT_WIDTH     = 14,
  parameter int RX_FIFO_DEPTH    = 64,
  parameter int CREDIT_THRESHOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [7:0]              line_out_data,
  output logic                    line_out_enable,
  input  logic                    line_out_done,
  input  logic [7:0]              line_in_data,
  input  logic                    line_in_enable,
  input  logic                    logic_rst_req,
  output logic [CREDIT_WIDTH-1:0] tx_credit,
  output logic                    error
);

  localparam int CNT_W = $clog2(RX_FIFO_DEPTH) + 1;
  localparam int HI_W  = CREDIT_WIDTH - 8;
  localparam logic [CREDIT_WIDTH:0] CREDIT_MAX = {1'b0, {CREDIT_WIDTH{1'b1}}};
  localparam logic [CREDIT_WIDTH:0] DEPTH_C    = (CREDIT_WIDTH+1)'(RX_FIFO_DEPTH);
  localparam logic [CREDIT_WIDTH:0] THRESH_C   = (CREDIT_WIDTH+1)'(CREDIT_THRESHOLD);

  dec_state_t              r_dec_state;
  logic [HI_W-1:0]         r_cred_hi;
  enc_state_t              r_enc_state;
  msg_kind_t               r_enc_kind;
  logic [7:0]              r_line_data;
  logic                    r_line_en;
  logic [CREDIT_WIDTH-1:0] r_tx_credit;
  logic [CREDIT_WIDTH-1:0] r_outstanding;
  logic [CREDIT_WIDTH-1:0] r_cred_val;
  logic                    r_cred_pend;
  logic                    r_rst_pend;
  logic                    r_error;

  logic                    w_dec_push;
  logic                    w_dec_cred;
  logic                    w_dec_err;
  logic [CREDIT_WIDTH-1:0] w_cred_add;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic [7:0]              w_fifo_data;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_tx_xfer;
  logic                    w_grant_done;
  logic [CREDIT_WIDTH:0]   w_tx_sum;
  logic [CREDIT_WIDTH:0]   w_out_sum;
  logic [CREDIT_WIDTH:0]   w_out_next;
  logic [CREDIT_WIDTH:0]   w_used;
  logic [CREDIT_WIDTH:0]   w_free;
  logic                    w_grant_now;

  // ---------------- ingress decoder ----------------
  always_comb begin
    w_dec_push = 1'b0;
    w_dec_cred = 1'b0;
    w_dec_err  = 1'b0;
    if (line_in_enable) begin
      case (r_dec_state)
        DEC_IDLE:    w_dec_push = (line_in_data != ESC);
        DEC_ESC: begin
          if (line_in_data == ESC)                     w_dec_push = 1'b1;
          else if (line_in_data[7:6] != CREDIT_HI_TAG) w_dec_err  = 1'b1;
        end
        DEC_CRED_LO: w_dec_cred = 1'b1;
        default:     w_dec_err  = 1'b0;
      endcase
    end
  end

  assign w_cred_add = w_dec_cred ? {r_cred_hi, line_in_data} : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dec_state <= DEC_IDLE;
      r_cred_hi   <= '0;
    end else if (line_in_enable) begin
      case (r_dec_state)
        DEC_IDLE: if (line_in_data == ESC) r_dec_state <= DEC_ESC;
        DEC_ESC: begin
          if (line_in_data != ESC && line_in_data[7:6] == CREDIT_HI_TAG) begin
            r_cred_hi   <= line_in_data[HI_W-1:0];
            r_dec_state <= DEC_CRED_LO;
          end else begin
            r_dec_state <= DEC_IDLE;
          end
        end
        default: r_dec_state <= DEC_IDLE;
      endcase
    end
  end

  glip_uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_dec_push),
    .i_data  (line_in_data),
    .i_pop   (rx_ready),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  assign rx_valid = ~w_fifo_empty;
  assign rx_data  = w_fifo_empty ? 8'h00 : w_fifo_data;

  // ---------------- credit accounting ----------------
  assign w_tx_xfer    = tx_valid & tx_ready;
  // BYTE2 only exists in credit messages, so its done closes a grant.
  assign w_grant_done = (r_enc_state == ENC_BYTE2) & line_out_done;
  assign w_tx_sum     = {1'b0, r_tx_credit} + {1'b0, w_cred_add}
                        - (CREDIT_WIDTH+1)'(w_tx_xfer);
  assign w_out_sum    = {1'b0, r_outstanding}
                        + (w_grant_done ? {1'b0, r_cred_val} : '0);
  assign w_out_next   = (w_dec_push && w_out_sum != '0) ? w_out_sum - 1'b1 : w_out_sum;
  assign w_used       = (CREDIT_WIDTH+1)'(w_fifo_count) + {1'b0, r_outstanding};
  assign w_free       = (w_used >= DEPTH_C) ? '0 : DEPTH_C - w_used;
  // r_cred_pend stays set until the message has fully left the line, so the
  // same space is never granted twice.
  assign w_grant_now  = ~r_cred_pend & (w_free >= THRESH_C);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_credit   <= '0;
      r_outstanding <= '0;
      r_cred_val    <= '0;
      r_cred_pend   <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_tx_credit   <= (w_tx_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_WIDTH-1:0]
                                               : w_tx_sum[CREDIT_WIDTH-1:0];
      r_outstanding <= (w_out_next > CREDIT_MAX) ? CREDIT_MAX[CREDIT_WIDTH-1:0]
                                                 : w_out_next[CREDIT_WIDTH-1:0];
      if (w_grant_now) begin
        r_cred_pend <= 1'b1;
        r_cred_val  <= w_free[CREDIT_WIDTH-1:0];
      end else if (w_grant_done) begin
        r_cred_pend <= 1'b0;
      end
      if (w_dec_err || (w_dec_push && (w_fifo_full || r_outstanding == '0))) begin
        r_error <= 1'b1;
      end
    end
  end

  // ---------------- egress encoder ----------------
  assign tx_ready = (r_enc_state == ENC_IDLE) & (r_tx_credit != '0)
                    & ~r_rst_pend & ~r_cred_pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_enc_state <= ENC_IDLE;
      r_enc_kind  <= MSG_DATA;
      r_line_data <= '0;
      r_line_en   <= 1'b0;
      r_rst_pend  <= 1'b0;
    end else begin
      if (logic_rst_req) r_rst_pend <= 1'b1;
      case (r_enc_state)
        ENC_IDLE: begin
          if (r_rst_pend) begin
            r_enc_kind  <= MSG_RST;
            r_line_data <= ESC;
            r_line_en   <= 1'b1;
            r_enc_state <= ENC_BYTE0;
            if (!logic_rst_req) r_rst_pend <= 1'b0;
          end else if (r_cred_pend) begin
            r_enc_kind  <= MSG_CREDIT;
            r_line_data <= ESC;
            r_line_en   <= 1'b1;
            r_enc_state <= ENC_BYTE0;
          end else if (w_tx_xfer) begin
            r_enc_kind  <= MSG_DATA;
            r_line_data <= tx_data;
            r_line_en   <= 1'b1;
            r_enc_state <= ENC_BYTE0;
          end
        end
        ENC_BYTE0: begin
          if (line_out_done) begin
            case (r_enc_kind)
              MSG_RST: begin
                r_line_data <= CMD_LOGIC_RST;
                r_enc_state <= ENC_BYTE1;
              end
              MSG_CREDIT: begin
                r_line_data <= {CREDIT_HI_TAG, r_cred_val[CREDIT_WIDTH-1:8]};
                r_enc_state <= ENC_BYTE1;
              end
              default: begin
                // A data FE needs a second FE; anything else is done.
                if (r_line_data == ESC) begin
                  r_enc_state <= ENC_BYTE1;
                end else begin
                  r_line_en   <= 1'b0;
                  r_enc_state <= ENC_IDLE;
                end
              end
            endcase
          end
        end
        ENC_BYTE1: begin
          if (line_out_done) begin
            if (r_enc_kind == MSG_CREDIT) begin
              r_line_data <= r_cred_val[7:0];
              r_enc_state <= ENC_BYTE2;
            end else begin
              r_line_en   <= 1'b0;
              r_enc_state <= ENC_IDLE;
            end
          end
        end
        default: begin
          if (line_out_done) begin
            r_line_en   <= 1'b0;
            r_enc_state <= ENC_IDLE;
          end
        end
      endcase
    end
  end

  assign line_out_data   = r_line_data;
  assign line_out_enable = r_line_en;
  assign tx_credit       = r_tx_credit;
  assign error           = r_error;

endmodule

// File: tb/tb_glip_uart_peer.sv
module tb_glip_uart_peer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  line_out_data;
  logic        line_out_enable;
  logic        line_out_done;
  logic [7:0]  line_in_data;
  logic        line_in_enable;
  logic        logic_rst_req;
  logic [13:0] tx_credit;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  b;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_err;
    logic [13:0] exp_cred;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  glip_uart_peer dut (
    .clk             (clk),
    .rst             (rst),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .line_out_data   (line_out_data),
    .line_out_enable (line_out_enable),
    .line_out_done   (line_out_done),
    .line_in_data    (line_in_data),
    .line_in_enable  (line_in_enable),
    .logic_rst_req   (logic_rst_req),
    .tx_credit       (tx_credit),
    .error           (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_in(input logic [7:0] b);
    line_in_data   = b;
    line_in_enable = 1'b1;
    tick();
    line_in_enable = 1'b0;
  endtask

  // Wait for the transmitter enable, let the byte sit a couple of cycles,
  // compare it, then acknowledge with a one-cycle done pulse.
  task automatic expect_out(input string name, input logic [7:0] exp);
    int n = 0;
    while (!line_out_enable && n < 200) begin
      tick();
      n++;
    end
    if (!line_out_enable) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for line_out_enable, expected byte 0x%0h", name, exp);
    end else begin
      repeat (2) tick();
      check(name, {24'd0, line_out_data}, {24'd0, exp});
      line_out_done = 1'b1;
      tick();
      line_out_done = 1'b0;
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (line_out_enable) seen = 1'b1;
      tick();
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  // Wait for tx_ready; the following edge performs the transfer.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout waiting for tx_ready, expected 1", name);
    end else begin
      tick();
    end
  endtask

  task automatic reset_and_grant(input string name);
    rst = 1'b0;
    tx_valid = 1'b0; rx_ready = 1'b0; line_out_done = 1'b0;
    line_in_enable = 1'b0; logic_rst_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    expect_out({name, " grant b0"}, 8'hFE);
    expect_out({name, " grant b1"}, 8'h80);
    expect_out({name, " grant b2"}, 8'h40);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 8'h41, 1'b0, 14'd0};
    vecs[1]  = '{8'hFE, 1'b0, 8'h00, 1'b0, 14'd0};
    vecs[2]  = '{8'hFE, 1'b1, 8'hFE, 1'b0, 14'd0};
    vecs[3]  = '{8'h42, 1'b1, 8'h42, 1'b0, 14'd0};
    vecs[4]  = '{8'hFE, 1'b0, 8'h00, 1'b0, 14'd0};
    vecs[5]  = '{8'h80, 1'b0, 8'h00, 1'b0, 14'd0};
    vecs[6]  = '{8'h03, 1'b0, 8'h00, 1'b0, 14'd3};
    vecs[7]  = '{8'h55, 1'b1, 8'h55, 1'b0, 14'd3};
    vecs[8]  = '{8'hFE, 1'b0, 8'h00, 1'b0, 14'd3};
    vecs[9]  = '{8'h05, 1'b0, 8'h00, 1'b1, 14'd3};
    vecs[10] = '{8'h66, 1'b1, 8'h66, 1'b1, 14'd3};

    rst = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    line_out_done = 1'b0; line_in_data = 8'h00; line_in_enable = 1'b0;
    logic_rst_req = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst line_out_enable", {31'd0, line_out_enable}, 32'd0);
    check("rst line_out_data", {24'd0, line_out_data}, 32'd0);
    check("rst tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst rx_data", {24'd0, rx_data}, 32'd0);
    check("rst tx_credit", {18'd0, tx_credit}, 32'd0);
    check("rst error", {31'd0, error}, 32'd0);

    // Initial grant after release
    rst = 1'b1;
    expect_out("init grant b0", 8'hFE);
    expect_out("init grant b1", 8'h80);
    expect_out("init grant b2", 8'h40);
    expect_quiet("init idle", 10);

    // No credit: data held
    tx_data = 8'h41; tx_valid = 1'b1;
    expect_quiet("nocred quiet", 10);
    check("nocred tx_ready", {31'd0, tx_ready}, 32'd0);
    send_in(8'hFE); send_in(8'h80); send_in(8'h02);
    check("cred2 tx_credit", {18'd0, tx_credit}, 32'd2);
    wait_ready("xfer 41");
    tx_data = 8'h42;
    expect_out("data 41", 8'h41);
    wait_ready("xfer 42");
    tx_data = 8'h43;
    expect_out("data 42", 8'h42);
    check("after 42 tx_credit", {18'd0, tx_credit}, 32'd0);
    check("43 held tx_ready", {31'd0, tx_ready}, 32'd0);
    expect_quiet("43 held quiet", 10);
    tx_valid = 1'b0;

    // Escaped FE data
    send_in(8'hFE); send_in(8'h80); send_in(8'h01);
    tx_data = 8'hFE; tx_valid = 1'b1;
    wait_ready("xfer FE");
    tx_valid = 1'b0;
    check("FE tx_credit", {18'd0, tx_credit}, 32'd0);
    expect_out("data FE b0", 8'hFE);
    expect_out("data FE b1", 8'hFE);
    expect_quiet("FE idle", 8);

    // Decoder table
    rx_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send_in(vecs[i].b);
      check($sformatf("vec%0d rx_valid", i), {31'd0, rx_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d tx_credit", i), {18'd0, tx_credit}, {18'd0, vecs[i].exp_cred});
    end
    repeat (10) tick();
    check("error sticky", {31'd0, error}, 32'd1);

    // Fill rx buffer, no grant until 16 popped
    reset_and_grant("fill");
    check("error cleared by reset", {31'd0, error}, 32'd0);
    for (int i = 0; i < 64; i++) send_in(8'(i));
    check("fill rx_valid", {31'd0, rx_valid}, 32'd1);
    check("fill error", {31'd0, error}, 32'd0);
    expect_quiet("fill no credit", 20);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pop%0d rx_data", i), {24'd0, rx_data}, i);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    expect_out("regrant b0", 8'hFE);
    expect_out("regrant b1", 8'h80);
    expect_out("regrant b2", 8'h10);

    // Overflow: 65th byte dropped
    reset_and_grant("ovf");
    for (int i = 0; i < 64; i++) send_in(8'(i + 8'h20));
    check("ovf pre error", {31'd0, error}, 32'd0);
    send_in(8'hAA);
    check("ovf error", {31'd0, error}, 32'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == 0 || i == 63)
        check($sformatf("ovf pop%0d rx_data", i), {24'd0, rx_data}, i + 32'h20);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    check("ovf dropped rx_valid", {31'd0, rx_valid}, 32'd0);

    // Arbitration: logic reset > credit > data
    reset_and_grant("arb");
    send_in(8'hFE); send_in(8'h80); send_in(8'h02);
    tx_data = 8'h10; tx_valid = 1'b1;
    wait_ready("xfer 10");
    tx_data = 8'h33;
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_in(8'h50);
    repeat (3) tick();
    rx_ready = 1'b0;
    logic_rst_req = 1'b1; tick(); logic_rst_req = 1'b0; tick();
    logic_rst_req = 1'b1; tick(); logic_rst_req = 1'b0;
    expect_out("arb data 10", 8'h10);
    expect_out("arb rst b0", 8'hFE);
    expect_out("arb rst b1", 8'h01);
    expect_out("arb cred b0", 8'hFE);
    expect_out("arb cred b1", 8'h80);
    expect_out("arb cred b2", 8'h10);
    expect_out("arb data 33", 8'h33);
    tx_valid = 1'b0;
    expect_quiet("arb merged", 10);

    // Reset in the middle of a message
    logic_rst_req = 1'b1; tick(); logic_rst_req = 1'b0;
    expect_out("abort b0", 8'hFE);
    check("abort mid enable", {31'd0, line_out_enable}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort enable low", {31'd0, line_out_enable}, 32'd0);
    rst = 1'b1;
    expect_out("abort grant b0", 8'hFE);
    expect_out("abort grant b1", 8'h80);
    expect_out("abort grant b2", 8'h40);
    expect_quiet("abort idle", 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
